// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port and memory-side 64-bit burst port of the cacheline adaptor.
// Read latency depends on memory; requests are held until resp_o and memory beats until they are accepted.
interface cacheline_adaptor_if;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// 256-bit line <-> 4 x 64-bit burst adaptor; resp_o one cycle after the 4th accepted beat, beats stall on resp_i low.
// CACHELINE_ADAPTOR_WRITE_POSTING_EN acknowledges writes right after capture and finishes the burst in the background.
module cacheline_adaptor (
    input  logic              clk,
    input  logic              rst,
    cacheline_adaptor_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_cnt;
    logic [31:0]  r_addr;
    logic [255:0] r_rline;
    logic [255:0] r_wline;
    logic         w_capture;
    logic         w_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.read_i || bus.write_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = bus.write_i ? WR_BURST : RD_BURST;
                end
            end
            RD_BURST, WR_BURST: begin
                if (bus.resp_i) begin
                    w_beat = 1'b1;
                    if (r_cnt == 2'd3) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_addr  <= 32'd0;
            r_rline <= 256'd0;
            r_wline <= 256'd0;
        end else begin
            if (w_capture) begin
                r_addr <= bus.address_i & ~32'h1F;
                if (bus.write_i) begin
                    r_wline <= bus.line_i;
                end
            end
            // counter wraps to 0 on the 4th beat, ready for the next line
            if (w_beat) begin
                r_cnt <= r_cnt + 2'd1;
                if (r_state == RD_BURST) begin
                    r_rline[{r_cnt, 6'b0} +: 64] <= bus.burst_i;
                end
            end
        end
    end

`ifdef CACHELINE_ADAPTOR_WRITE_POSTING_EN
    logic r_wr_op;
    logic r_post_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_op     <= 1'b0;
            r_post_resp <= 1'b0;
        end else begin
            r_post_resp <= w_capture & bus.write_i;
            if (w_capture) begin
                r_wr_op <= bus.write_i;
            end
        end
    end

    // writes were already acknowledged, so DONE stays silent for them
    assign bus.resp_o = ((r_state == DONE) && !r_wr_op) || r_post_resp;
`else
    assign bus.resp_o = (r_state == DONE);
`endif

    assign bus.read_o    = (r_state == RD_BURST);
    assign bus.write_o   = (r_state == WR_BURST);
    assign bus.burst_o   = r_wline[{r_cnt, 6'b0} +: 64];
    assign bus.address_o = r_addr;
    assign bus.line_o    = r_rline;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed scoreboard bench for cacheline_adaptor: requests push expectations, a negedge monitor pops and compares.
module tb_cacheline_adaptor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cacheline_adaptor_if bus();

    cacheline_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit           is_wr;
        logic [31:0]  addr;
        logic [255:0] line;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    logic [63:0]  wq[$];
    logic [63:0]  rd_q[$];
    bit           pat_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic [255:0] last_rd_line = '0;
    bit           seen = 1'b0;

    localparam logic [255:0] WLINE  = 256'h0011223344556677_8899AABBCCDDEEFF_FEDCBA9876543210_0123456789ABCDEF;
    localparam logic [255:0] WLINE2 = 256'hA5A5A5A5A5A5A5A5_0F0F0F0F0F0F0F0F_1357913579135791_2468024680246802;
    localparam logic [255:0] RLINE1 = {64'h4444444444444444, 64'h3333333333333333,
                                       64'h2222222222222222, 64'h1111111111111111};
    localparam logic [255:0] RLINE2 = {64'hDDDD0000DDDD0003, 64'hCCCC0000CCCC0002,
                                       64'hBBBB0000BBBB0001, 64'hAAAA0000AAAA0000};
    localparam logic [255:0] RLINE3 = {64'h8888888888888888, 64'h7777777777777777,
                                       64'h6666666666666666, 64'h5555555555555555};
    localparam logic [255:0] RJUNK  = {64'hDEAD00000000DEAD, 64'hDEAD00000000BEEF,
                                       64'hFACE00000000CAFE, 64'hBAD00000000F00D};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory model: starts answering one cycle after it first sees read_o/write_o
    always @(posedge clk) begin
        bit act_now;
        #1;
        if (rst) begin
            bus.resp_i = 1'b0;
            seen = 1'b0;
        end else begin
            act_now = bus.read_o || bus.write_o;
            if (seen && act_now && pat_q.size() > 0) begin
                bus.resp_i = pat_q.pop_front();
                if (bus.resp_i && bus.read_o && rd_q.size() > 0) begin
                    bus.burst_i = rd_q.pop_front();
                end
            end else begin
                bus.resp_i = 1'b0;
            end
            seen = act_now;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.resp_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got resp_o=1 at cycle %0d required none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc >= 0) chk("resp_cycle", cyc, e.cyc);
                    chk("address_o", bus.address_o, e.addr);
                    chk(e.is_wr ? "line_o_after_write" : "line_o_read", bus.line_o, e.line);
                end
            end
            if (bus.write_o && bus.resp_i) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wbeat: got burst_o=%h required no beat", bus.burst_o);
                end else begin
                    chk("burst_o_beat", bus.burst_o, wq.pop_front());
                end
            end
            if (bus.write_o) chk("read_o_during_write", bus.read_o, 1'b0);
        end
    end

    // issued at posedge+1; holds the request until resp_o, then drops it at the next posedge+1
    task automatic do_req(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [255:0] wline, input logic [255:0] rbeats,
                          input logic [7:0] pat, input int plen, input bit chk_cyc);
        exp_t e;
        int   last;
        bit   got;
        last = 0;
        for (int i = 0; i < plen; i++) begin
            pat_q.push_back(pat[i]);
            if (pat[i]) last = i;
        end
        e.is_wr = wr;
        e.addr  = addr & 32'hFFFF_FFE0;
        if (wr) begin
            for (int k = 0; k < 4; k++) wq.push_back(wline[64*k +: 64]);
            e.line = last_rd_line;
        end else begin
            for (int k = 0; k < 4; k++) rd_q.push_back(rbeats[64*k +: 64]);
            e.line = rbeats;
            last_rd_line = rbeats;
        end
`ifdef CACHELINE_ADAPTOR_WRITE_POSTING_EN
        e.cyc = !chk_cyc ? -1 : (wr ? cyc + 1 : cyc + 3 + last);
`else
        e.cyc = chk_cyc ? cyc + 3 + last : -1;
`endif
        sb.push_back(e);
        bus.address_i = addr;
        bus.line_i    = wline;
        bus.write_i   = wr;
        bus.read_i    = rd;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (bus.resp_o) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: got no resp_o for addr %h required one within 60 cycles", addr);
        end
        @(posedge clk);
        #1;
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_read_o"},    bus.read_o,    1'b0);
        chk({tag, "_write_o"},   bus.write_o,   1'b0);
        chk({tag, "_resp_o"},    bus.resp_o,    1'b0);
        chk({tag, "_burst_o"},   bus.burst_o,   64'd0);
        chk({tag, "_address_o"}, bus.address_o, 32'd0);
        chk({tag, "_line_o"},    bus.line_o,    256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.line_i    = '0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        do_req(1'b0, 1'b1, 32'h0000_1234, '0, RLINE1, 8'b0000_1111, 4, 1'b1);
        do_req(1'b1, 1'b0, 32'hDEAD_BEEF, WLINE, '0, 8'b0000_1111, 4, 1'b1);
        do_req(1'b0, 1'b1, 32'h0000_2008, '0, RLINE2, 8'b0101_1001, 7, 1'b1);
        do_req(1'b1, 1'b1, 32'h0000_0047, WLINE2, '0, 8'b1010_0101, 8, 1'b1);

        // reset after two beats of a read: everything clears at once, no completion expected
        for (int i = 0; i < 4; i++) begin
            pat_q.push_back(1'b1);
            rd_q.push_back(RJUNK[64*i +: 64]);
        end
        bus.address_i = 32'h0000_0300;
        bus.read_i    = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        #1;
        chk_all_zero("midburst_reset");
        bus.read_i = 1'b0;
        pat_q.delete();
        rd_q.delete();
        last_rd_line = '0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        do_req(1'b0, 1'b1, 32'h0000_0400, '0, RLINE3, 8'b0000_1111, 4, 1'b1);

`ifdef CACHELINE_ADAPTOR_WRITE_POSTING_EN
        do_req(1'b1, 1'b0, 32'h0000_5000, WLINE, '0, 8'b0000_1111, 4, 1'b1);
        do_req(1'b0, 1'b1, 32'h0000_6010, '0, RLINE1, 8'b0000_1111, 4, 1'b0);
`endif

        repeat (10) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("wbeats_drained", wq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port line_i  input  256  write-back line from the cache.
REQ-004 SHALL have port line_o  output  256  assembled fill line to the cache.
REQ-005 SHALL have port address_i  input  32  line address from the cache.
REQ-006 SHALL have port read_i  input  1  line-read request, held high until resp_o.
REQ-007 SHALL have port write_i  input  1  line-write request, held high until resp_o.
REQ-008 SHALL have port resp_o  output  1  one-cycle line-transfer-complete pulse.
REQ-009 SHALL have port burst_i  input  64  read beat from memory.
REQ-010 SHALL have port burst_o  output  64  write beat to memory.
REQ-011 SHALL have port address_o  output  32  burst address, {address_i[31:5], 5'b0} as latched at request capture.
REQ-012 SHALL have ports read_o and write_o  output  1 each  burst request to memory.
REQ-013 SHALL have port resp_i  input  1  per-beat valid from memory.

Function
REQ-014 SHALL implement states IDLE, RD_BURST, WR_BURST and DONE.
REQ-015 In IDLE with read_i or write_i high, SHALL latch address and, for a write, line_i, then go to WR_BURST if write_i is high, otherwise RD_BURST; write wins when both are high.
REQ-016 SHALL assert read_o (RD_BURST) or write_o (WR_BURST) from the cycle after capture until the cycle in which the 4th beat is accepted, inclusive.
REQ-017 SHALL count beats with a 2-bit counter that increments only on a clock edge with resp_i high; beat k maps to line bits [64k+63:64k], with beat 0 first.
REQ-018 In RD_BURST, SHALL store burst_i into line slice k on each edge where resp_i is high.
REQ-019 In WR_BURST, SHALL drive burst_o with line slice k for the current counter value k at all times.
REQ-020 On the edge accepting beat 3, the counter SHALL wrap to 0 and the state SHALL go to DONE.
REQ-021 In DONE, SHALL assert resp_o for exactly one cycle, with line_o holding the full line, then return to IDLE.
REQ-022 Read latency SHALL be request-to-resp_o = 1 + (cycles until the 4th resp_i) + 1; minimum 6 cycles with back-to-back beats.
REQ-023 resp_i gaps mid-burst SHALL stall the counter, with no data loss.
REQ-024 resp_i while in IDLE or DONE SHALL be ignored.
REQ-025 Requests SHALL be sampled only in IDLE, so a request held high during DONE is not re-captured in that cycle.
REQ-026 line_o SHALL hold the last assembled line until the next read burst overwrites it.

Reset
REQ-027 On rst high, at any time including mid-burst, SHALL enter IDLE with counter 0 and read_o=write_o=resp_o=0, and burst_o, address_o and line_o all 0; any partial burst SHALL be abandoned.
REQ-028 After rst deasserts, the first request SHALL be accepted in the first IDLE cycle.

Configuration
REQ-029 Macro CACHELINE_ADAPTOR_WRITE_POSTING_EN: when defined, a write SHALL pulse resp_o in the cycle after capture, and the burst SHALL complete in the background.
REQ-030 With that macro defined, any request arriving while the posted burst is still in progress SHALL wait in IDLE-pending until write_o drops, and then be captured.
REQ-031 With that macro defined, a write SHALL NOT also produce a resp_o pulse in DONE.
REQ-032 Without the macro, writes SHALL behave exactly as REQ-016 to REQ-021.

Verification
REQ-033 Read line: read_i, address_i=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> address_o=0x0000_1220; resp_o at request cycle+6; line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
REQ-034 Write line: write_i, line_i=256'h0123...CDEF -> burst_o presents slices 0..3 in order on successive resp_i edges; write_o drops after beat 3; resp_o occurs 1 cycle later (immediately with the macro).
REQ-035 Gapped read: resp_i pattern 1,0,0,1,1,0,1 -> line assembled correctly; resp_o one cycle after the final beat.
REQ-036 Reset mid-burst: rst asserted after 2 read beats -> all outputs 0 asynchronously; a following read returns a correct line with counter restarted at beat 0.
REQ-037 Simultaneous read_i and write_i -> write burst performed, read_o stays 0.
REQ-038 With the macro: posted write followed immediately by read_i -> read_o stays 0 until write_o falls; read then completes correctly.
